// File: rtl/aes_col_to_row_streamer.sv
`default_nettype none
// ============================================================================
// Module      : aes_col_to_row_streamer
// Description : Transposes a column-major 128-bit AES state into row-major
//               order and streams it as four 32-bit row words (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_col_to_row_streamer #(
    parameter int OVERLAP      = 1,
    parameter int WORD_REVERSE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic [1:0]   m_row,
    output logic         m_last,
    output logic [127:0] row_blk,
    output logic         blk_done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_beat;
    logic [1:0]   w_beat_nxt;
    logic [127:0] r_buf;
    logic [127:0] w_buf_nxt;
    logic [127:0] r_row_blk;
    logic [127:0] w_row_blk_nxt;
    logic         r_blk_done;
    logic         w_done_nxt;
    logic [127:0] w_reordered;
    logic [1:0]   w_row;

    // Row-major byte 4w+j takes column-major byte 4j+w (a 4x4 byte transpose).
    function automatic logic [127:0] col_to_row(input logic [127:0] c);
        logic [127:0] r;
        r = '0;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) begin
                r[127-8*(4*w+j) -: 8] = c[127-8*(4*j+w) -: 8];
            end
        end
        return r;
    endfunction

    assign w_reordered = col_to_row(s_data);
    assign w_row       = (WORD_REVERSE != 0) ? (2'd3 - r_beat) : r_beat;

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_buf_nxt     = r_buf;
        w_row_blk_nxt = r_row_blk;
        w_done_nxt    = 1'b0;
        s_ready       = 1'b0;
        m_valid       = 1'b0;
        m_data        = '0;
        m_row         = '0;
        m_last        = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_ready = !rst;
            end
            S_SEND: begin
                m_valid = 1'b1;
                m_data  = r_buf[127-32*w_row -: 32];
                m_row   = w_row;
                m_last  = (r_beat == 2'd3);
                if (m_ready) begin
                    if (r_beat == 2'd3) begin
                        w_done_nxt  = 1'b1;
                        w_beat_nxt  = 2'd0;
                        w_state_nxt = S_IDLE;
                        // Taking the next block on the final beat removes the bubble.
                        if (OVERLAP != 0) begin
                            s_ready = !rst;
                        end
                    end else begin
                        w_beat_nxt = r_beat + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (s_valid && s_ready) begin
            w_buf_nxt     = w_reordered;
            w_row_blk_nxt = w_reordered;
            w_beat_nxt    = 2'd0;
            w_state_nxt   = S_SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= 2'd0;
            r_buf      <= '0;
            r_row_blk  <= '0;
            r_blk_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat     <= w_beat_nxt;
            r_buf      <= w_buf_nxt;
            r_row_blk  <= w_row_blk_nxt;
            r_blk_done <= w_done_nxt;
        end
    end

    assign row_blk  = r_row_blk;
    assign blk_done = r_blk_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_col_to_row_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_col_to_row_streamer
// Description : Scoreboard bench for two streamer configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_col_to_row_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] V1_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1_R = 128'h0004080c0105090d02060a0e03070b0f;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Build the column-major state from a row-major block via a 4x4 byte matrix.
    function automatic logic [127:0] row_to_col(input logic [127:0] r);
        logic [7:0]   m [4][4];
        logic [127:0] c;
        for (int i = 0; i < 16; i++) m[i/4][i%4] = r[127-8*i -: 8];
        for (int j = 0; j < 4; j++) c[127-32*j -: 32] = {m[0][j], m[1][j], m[2][j], m[3][j]};
        return c;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int OV = (k == 0) ? 1 : 0;
        localparam int WR = (k == 1) ? 1 : 0;

        logic         rst     = 1'b1;
        logic         s_valid = 1'b0;
        logic [127:0] s_data  = '0;
        logic         m_ready = 1'b0;
        logic         s_ready, m_valid, m_last, blk_done;
        logic [31:0]  m_data;
        logic [1:0]   m_row;
        logic [127:0] row_blk;
        int           rdy_mode = 1;
        bit           fin = 1'b0;
        logic [34:0]  q_word[$];
        logic [127:0] blk_q[$];

        aes_col_to_row_streamer #(.OVERLAP(OV), .WORD_REVERSE(WR)) u_dut (
            .clk(clk), .rst(rst),
            .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
            .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
            .m_row(m_row), .m_last(m_last), .row_blk(row_blk), .blk_done(blk_done)
        );

        always @(posedge clk) begin
            #2;
            if (rdy_mode == 2) m_ready = ($urandom_range(0, 3) != 0);
            else               m_ready = (rdy_mode == 1);
        end

        bit           started = 0, was_rst = 0, exp_done = 0, chk_hold = 0, chk_nv = 0, exp_nv = 0;
        logic [34:0]  held;
        logic [127:0] exp_rowblk = '0;

        always @(negedge clk) begin : mon
            logic [34:0]  e;
            logic [127:0] r;
            logic [1:0]   wr;
            bit           hs, acc, last_hs;
            if (rst) begin
                started = 1; was_rst = 1;
                check($sformatf("u%0d s_ready_in_reset", k), s_ready, 0);
                q_word.delete();
                exp_done = 0; chk_hold = 0; chk_nv = 0; exp_rowblk = '0;
            end else if (started) begin
                if (was_rst) begin
                    check($sformatf("u%0d post_reset_outputs", k),
                          {m_valid, m_last, m_row, m_data, blk_done}, 0);
                    was_rst = 0;
                end
                if (blk_done || exp_done) check($sformatf("u%0d blk_done", k), blk_done, exp_done);
                check($sformatf("u%0d row_blk", k), row_blk, exp_rowblk);
                if (chk_hold) check($sformatf("u%0d hold", k), {m_valid, m_row, m_last, m_data}, {1'b1, held});
                if (chk_nv) check($sformatf("u%0d m_valid_next", k), m_valid, exp_nv);
                check($sformatf("u%0d s_ready_rule", k), s_ready,
                      !m_valid || (OV != 0 && m_last && m_ready));
                hs = m_valid && m_ready;
                acc = s_valid && s_ready;
                last_hs = 0;
                exp_done = 0;
                if (hs) begin
                    if (q_word.size() == 0) begin
                        check($sformatf("u%0d unexpected_word", k), m_data, 0);
                    end else begin
                        e = q_word.pop_front();
                        check($sformatf("u%0d word", k), {m_row, m_last, m_data}, e);
                        last_hs = e[32];
                    end
                end
                exp_done = last_hs;
                chk_hold = m_valid && !hs;
                held = {m_row, m_last, m_data};
                chk_nv = 1;
                if (!m_valid)    exp_nv = acc;
                else if (last_hs) exp_nv = acc;
                else             exp_nv = 1;
                if (acc) begin
                    if (blk_q.size() == 0) begin
                        check($sformatf("u%0d unexpected_accept", k), 1, 0);
                    end else begin
                        r = blk_q.pop_front();
                        for (int i = 0; i < 4; i++) begin
                            wr = (WR != 0) ? 2'(3 - i) : 2'(i);
                            q_word.push_back({wr, (i == 3), r[127-32*wr -: 32]});
                        end
                        exp_rowblk = r;
                    end
                end
            end
        end

        task automatic send(input logic [127:0] r, input logic [127:0] c, input bit keep);
            int n;
            blk_q.push_back(r);
            s_valid = 1'b1;
            s_data  = c;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_ready && n < 200);
            if (!s_ready) begin
                check($sformatf("u%0d accept_timeout", k), 0, 1);
                void'(blk_q.pop_back());
                s_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                if (!keep) begin
                    s_valid = 1'b0;
                    s_data  = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        endtask

        initial begin : drv
            logic [127:0] rb;
            int n;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            rdy_mode = 1;
            send(V1_R, V1_C, 0);
            repeat (6) @(posedge clk);
            #1;
            // Hold the second beat under backpressure for three cycles.
            send(V1_R, V1_C, 0);
            @(posedge clk);
            #1 rdy_mode = 0;
            repeat (3) begin
                @(negedge clk);
                check($sformatf("u%0d bp_data", k), m_data, (WR != 0) ? 32'h02060a0e : 32'h0105090d);
                check($sformatf("u%0d bp_row", k), m_row, (WR != 0) ? 2'd2 : 2'd1);
            end
            @(posedge clk);
            #1 rdy_mode = 1;
            repeat (6) @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                rb = {$urandom, $urandom, $urandom, $urandom};
                send(rb, row_to_col(rb), i < 2);
            end
            repeat (8) @(posedge clk);
            #1;
            // Reset while the third beat is on the bus.
            send(V1_R, V1_C, 0);
            @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            send(V1_R, V1_C, 0);
            rdy_mode = 2;
            for (int i = 0; i < 1000; i++) begin
                rb = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 1) == 1) begin
                    send(rb, row_to_col(rb), 1);
                end else begin
                    send(rb, row_to_col(rb), 0);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            s_valid = 1'b0;
            rdy_mode = 1;
            n = 0;
            while (q_word.size() != 0 && n < 100) begin
                @(posedge clk);
                n++;
            end
            check($sformatf("u%0d drain", k), q_word.size(), 0);
            repeat (3) @(posedge clk);
            fin = 1'b1;
        end
    end

    initial begin : top
        int n;
        n = 0;
        while (!(g_inst[0].fin && g_inst[1].fin) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_inst[0].fin && g_inst[1].fin)) check("global_timeout", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
